pipeline_dest_tracker: RTL

- Carries each instruction's destination-register tag, register-file write enable and load flag through the EX, MEM and WB stages.
- Supplies the ex_/mem_/wb_ destination, rf_enable and load signals consumed by the hazard/forwarding unit.
- Consumes that unit's load_enable and nop_signal outputs to hold ID and inject bubbles.
- Also handles data-memory wait freezes, pipeline flush and saturating stall/bubble statistics.

---
 rtl/pipeline_dest_tracker.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipeline_dest_tracker.sv
// Carries destination tag, register-file write enable and load flag through EX/MEM/WB.
// Also provides freeze/flush handling and saturating stall/bubble statistics.
module pipeline_dest_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_destination,
  input  logic             id_rf_enable,
  input  logic             id_load_instruction,
  input  logic             load_enable,
  input  logic             nop_signal,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [REG_W-1:0] ex_destination,
  output logic [REG_W-1:0] mem_destination,
  output logic [REG_W-1:0] wb_destination,
  output logic             ex_rf_enable,
  output logic             mem_rf_enable,
  output logic             wb_rf_enable,
  output logic             ex_load_instruction,
  output logic             mem_load_instruction,
  output logic             id_hold,
  output logic             frozen,
  output logic [CNT_W-1:0] load_stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FREEZE = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic             pending_flush_reg;
  logic [REG_W-1:0] ex_dest_reg, mem_dest_reg, wb_dest_reg;
  logic             ex_rf_reg, mem_rf_reg, wb_rf_reg;
  logic             ex_ld_reg, mem_ld_reg;
  logic             advance, bubble;
  logic [REG_W-1:0] ex_dest_next;
  logic             ex_rf_next, ex_ld_next;

  // Advancing depends only on the live mem_ready, never on the registered state.
  assign advance = mem_ready;
  assign bubble  = nop_signal | flush | pending_flush_reg | ~id_valid | ~load_enable;

  // rf_enable is masked at EX entry so a zero tag never carries a write enable downstream.
  assign ex_dest_next = bubble ? '0 : id_destination;
  assign ex_rf_next   = ~bubble & id_rf_enable & (id_destination != '0);
  assign ex_ld_next   = ~bubble & id_load_instruction;

  assign state_next = advance ? ST_RUN : ST_FREEZE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_RUN;
      pending_flush_reg <= 1'b0;
      ex_dest_reg       <= '0;
      mem_dest_reg      <= '0;
      wb_dest_reg       <= '0;
      ex_rf_reg         <= 1'b0;
      mem_rf_reg        <= 1'b0;
      wb_rf_reg         <= 1'b0;
      ex_ld_reg         <= 1'b0;
      mem_ld_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (advance) begin
        pending_flush_reg <= 1'b0;
        wb_dest_reg       <= mem_dest_reg;
        wb_rf_reg         <= mem_rf_reg;
        mem_dest_reg      <= ex_dest_reg;
        mem_rf_reg        <= ex_rf_reg;
        mem_ld_reg        <= ex_ld_reg;
        ex_dest_reg       <= ex_dest_next;
        ex_rf_reg         <= ex_rf_next;
        ex_ld_reg         <= ex_ld_next;
      end else if (flush) begin
        pending_flush_reg <= 1'b1;
      end
    end
  end

  // Index 0: load-use stall cycles, index 1: bubbles displacing a real instruction.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = advance & ~load_enable;
  assign cnt_inc[1] = advance & bubble & id_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign ex_destination       = ex_dest_reg;
  assign mem_destination      = mem_dest_reg;
  assign wb_destination       = wb_dest_reg;
  assign ex_rf_enable         = ex_rf_reg;
  assign mem_rf_enable        = mem_rf_reg;
  assign wb_rf_enable         = wb_rf_reg;
  assign ex_load_instruction  = ex_ld_reg;
  assign mem_load_instruction = mem_ld_reg;
  assign id_hold              = ~load_enable | ~mem_ready;
  assign frozen               = (state_reg == ST_FREEZE);
  assign load_stall_count     = cnt_reg[0];
  assign bubble_count         = cnt_reg[1];

endmodule
